// File: rtl/blake_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : blake_pkg
//  Purpose  : BLAKE-512 constants (IV, pi constants, sigma permutations),
//             fixed 80-byte padding words, counter value and core states.
//  Revision : 1.0 - initial release
// ============================================================================
package blake_pkg;

    // Padding words for an 80-byte message placed in a single 1024-bit block
    localparam logic [63:0] PAD_M10 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] PAD_M13 = 64'h0000_0000_0000_0001;
    localparam logic [63:0] PAD_M15 = 64'h0000_0000_0000_0280;

    // Bit counter of the (only) block: 640 message bits
    localparam logic [63:0] CNT_T0 = 64'd640;
    localparam logic [63:0] CNT_T1 = 64'd0;

    // Initial chaining value (shared with SHA-512)
    localparam logic [0:7][63:0] BLAKE_IV = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
        64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
        64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    // Round constants: leading digits of pi
    localparam logic [0:15][63:0] BLAKE_C = {
        64'h243f6a8885a308d3, 64'h13198a2e03707344,
        64'ha4093822299f31d0, 64'h082efa98ec4e6c89,
        64'h452821e638d01377, 64'hbe5466cf34e90c6c,
        64'hc0ac29b7c97c50dd, 64'h3f84d5b5b5470917,
        64'h9216d5d98979fb1b, 64'hd1310ba698dfb5ac,
        64'h2ffd72dbd01adfb7, 64'hb8e1afed6a267e96,
        64'hba7c9045f12c7f99, 64'h24a19947b3916cf7,
        64'h0801f2e2858efc16, 64'h636920d871574e69
    };

    // Sigma permutations, one row per 64-bit word, entry 0 in the top nibble
    localparam logic [0:9][63:0] SIGMA_ROWS = {
        64'h0123456789abcdef, 64'hea489fd61c02b753,
        64'hb8c052fdae367194, 64'h7931dcbe265a40f8,
        64'h905724afe1bc683d, 64'h2c6a0b834d75fe19,
        64'hc51fed4a0763928b, 64'hdb7ec13950f4862a,
        64'h6fe9b308c2d714a5, 64'ha2847615fb9e3cd0
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Entry k of sigma row 'row'
    function automatic logic [3:0] sigma(input logic [3:0] row, input logic [3:0] k);
        logic [63:0] w_row;
        w_row = SIGMA_ROWS[row] >> {(4'd15 - k), 2'b00};
        return w_row[3:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/blake_hw_g.sv
`default_nettype none
// ============================================================================
//  Module   : blake_g
//  Purpose  : Combinational BLAKE-512 G mixing function on 64-bit words.
//             i_mx / i_my are the pre-combined message^constant terms.
//  Revision : 1.0 - initial release
// ============================================================================
module blake_g (
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    input  logic [63:0] i_c,
    input  logic [63:0] i_d,
    input  logic [63:0] i_mx,
    input  logic [63:0] i_my,
    output logic [63:0] o_a,
    output logic [63:0] o_b,
    output logic [63:0] o_c,
    output logic [63:0] o_d
);

    logic [63:0] w_a1, w_b1, w_c1, w_d1, w_x1, w_x2, w_x3, w_x4;

    assign w_a1 = i_a + i_b + i_mx;
    assign w_x1 = i_d ^ w_a1;
    assign w_d1 = {w_x1[31:0], w_x1[63:32]};
    assign w_c1 = i_c + w_d1;
    assign w_x2 = i_b ^ w_c1;
    assign w_b1 = {w_x2[24:0], w_x2[63:25]};

    assign o_a  = w_a1 + w_b1 + i_my;
    assign w_x3 = w_d1 ^ o_a;
    assign o_d  = {w_x3[15:0], w_x3[63:16]};
    assign o_c  = w_c1 + o_d;
    assign w_x4 = w_b1 ^ o_c;
    assign o_b  = {w_x4[10:0], w_x4[63:11]};

endmodule
`default_nettype wire

// File: rtl/blake_hw.sv
`default_nettype none
// ============================================================================
//  Module   : blake_hw
//  Purpose  : Iterative BLAKE-512 of a fixed 80-byte message. One half-round
//             (four parallel G) per clock; 33 clocks from ena to rdy.
//  Revision : 1.0 - initial release
// ============================================================================
module blake_hw
    import blake_pkg::*;
(
    input  logic         clk,
    input  logic         rstb,
    input  logic [639:0] din,
    input  logic         ena,
    output logic         rdy,
    output logic [511:0] dout
);

    state_t             state_q, state_d;
    logic [4:0]         step_q, step_d;
    logic [15:0][63:0]  v_q, v_d;
    logic [15:0][63:0]  m_q, m_d;
    logic               rdy_q, rdy_d;
    logic [511:0]       dout_q, dout_d;

    // Even step = column half-round, odd step = diagonal half-round
    logic [3:0] w_round;
    logic [3:0] w_row;
    logic       w_diag;

    assign w_round = step_q[4:1];
    assign w_diag  = step_q[0];
    assign w_row   = (w_round >= 4'd10) ? (w_round - 4'd10) : w_round;

    logic [3:0][3:0]  w_ia, w_ib, w_ic, w_id;
    logic [3:0][63:0] w_na, w_nb, w_nc, w_nd;

    generate
        for (genvar g = 0; g < 4; g++) begin : g_mix
            logic [3:0] w_sx, w_sy;
            logic [2:0] w_gi;

            assign w_gi    = {w_diag, 2'(g)};
            assign w_sx    = sigma(w_row, {w_gi, 1'b0});
            assign w_sy    = sigma(w_row, {w_gi, 1'b1});
            assign w_ia[g] = 4'(g);
            assign w_ib[g] = w_diag ? 4'(4  + ((g + 1) % 4)) : 4'(4  + g);
            assign w_ic[g] = w_diag ? 4'(8  + ((g + 2) % 4)) : 4'(8  + g);
            assign w_id[g] = w_diag ? 4'(12 + ((g + 3) % 4)) : 4'(12 + g);

            blake_g u_g (
                .i_a  (v_q[w_ia[g]]),
                .i_b  (v_q[w_ib[g]]),
                .i_c  (v_q[w_ic[g]]),
                .i_d  (v_q[w_id[g]]),
                .i_mx (m_q[w_sx] ^ BLAKE_C[w_sy]),
                .i_my (m_q[w_sy] ^ BLAKE_C[w_sx]),
                .o_a  (w_na[g]),
                .o_b  (w_nb[g]),
                .o_c  (w_nc[g]),
                .o_d  (w_nd[g])
            );
        end
    endgenerate

    // Next-state: load on ena when idle, 32 half-rounds, then one digest cycle
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        v_d     = v_q;
        m_d     = m_q;
        rdy_d   = 1'b0;
        dout_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (ena) begin
                    for (int k = 0; k < 10; k++) begin
                        m_d[k] = din[639 - 64*k -: 64];
                    end
                    m_d[10] = PAD_M10;
                    m_d[11] = '0;
                    m_d[12] = '0;
                    m_d[13] = PAD_M13;
                    m_d[14] = '0;
                    m_d[15] = PAD_M15;
                    for (int k = 0; k < 8; k++) begin
                        v_d[k] = BLAKE_IV[k];
                    end
                    for (int k = 0; k < 4; k++) begin
                        v_d[8 + k] = BLAKE_C[k];
                    end
                    v_d[12] = BLAKE_C[4] ^ CNT_T0;
                    v_d[13] = BLAKE_C[5] ^ CNT_T0;
                    v_d[14] = BLAKE_C[6] ^ CNT_T1;
                    v_d[15] = BLAKE_C[7] ^ CNT_T1;
                    step_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int g = 0; g < 4; g++) begin
                    v_d[w_ia[g]] = w_na[g];
                    v_d[w_ib[g]] = w_nb[g];
                    v_d[w_ic[g]] = w_nc[g];
                    v_d[w_id[g]] = w_nd[g];
                end
                step_d = step_q + 5'd1;
                if (step_q == 5'd31) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                for (int j = 0; j < 8; j++) begin
                    dout_d[(7 - j)*64 +: 64] = BLAKE_IV[j] ^ v_q[j] ^ v_q[j + 8];
                end
                rdy_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, working registers and registered outputs
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            v_q     <= '0;
            m_q     <= '0;
            rdy_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            v_q     <= v_d;
            m_q     <= m_d;
            rdy_q   <= rdy_d;
            dout_q  <= dout_d;
        end
    end

    assign rdy  = rdy_q;
    assign dout = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_blake_hw.sv
`default_nettype none
// ============================================================================
//  Module   : tb_blake_hw
//  Purpose  : Self-checking bench for blake_hw against a byte-level
//             BLAKE-512 software model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_blake_hw;

    logic         clk;
    logic         rstb;
    logic [639:0] din;
    logic         ena;
    logic         rdy;
    logic [511:0] dout;

    int n_tests = 0;
    int n_fail  = 0;

    blake_hw u_dut (
        .clk  (clk),
        .rstb (rstb),
        .din  (din),
        .ena  (ena),
        .rdy  (rdy),
        .dout (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [63:0] TB_IV [8] = '{
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };
    localparam logic [63:0] TB_C [16] = '{
        64'h243f6a8885a308d3, 64'h13198a2e03707344, 64'ha4093822299f31d0, 64'h082efa98ec4e6c89,
        64'h452821e638d01377, 64'hbe5466cf34e90c6c, 64'hc0ac29b7c97c50dd, 64'h3f84d5b5b5470917,
        64'h9216d5d98979fb1b, 64'hd1310ba698dfb5ac, 64'h2ffd72dbd01adfb7, 64'hb8e1afed6a267e96,
        64'hba7c9045f12c7f99, 64'h24a19947b3916cf7, 64'h0801f2e2858efc16, 64'h636920d871574e69
    };
    localparam int SIG [10][16] = '{
        '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
        '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
        '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
        '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
        '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
        '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
        '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
        '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
        '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
        '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}
    };
    localparam int GA [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    localparam int GB [8] = '{4, 5, 6, 7, 5, 6, 7, 4};
    localparam int GC [8] = '{8, 9, 10, 11, 10, 11, 8, 9};
    localparam int GD [8] = '{12, 13, 14, 15, 15, 12, 13, 14};

    function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Returns {a, b, c, d} after one G
    function automatic logic [255:0] gmix(input logic [63:0] a, b, c, d, mx, my);
        a = a + b + mx; d = ror64(d ^ a, 32); c = c + d; b = ror64(b ^ c, 25);
        a = a + b + my; d = ror64(d ^ a, 16); c = c + d; b = ror64(b ^ c, 11);
        return {a, b, c, d};
    endfunction

    // BLAKE-512 of an 80-byte message, padding built at byte level
    function automatic logic [511:0] ref_blake512(input logic [639:0] msg);
        logic [7:0]   blk [128];
        logic [63:0]  m [16];
        logic [63:0]  v [16];
        logic [255:0] res;
        logic [511:0] h;
        int           s;
        for (int i = 0; i < 128; i++) blk[i] = 8'h00;
        for (int i = 0; i < 80; i++) blk[i] = msg[639 - 8*i -: 8];
        blk[80]  = 8'h80;
        blk[111] = blk[111] | 8'h01;
        blk[126] = 8'h02;      // length 640 = 0x0280, big-endian 128-bit
        blk[127] = 8'h80;
        for (int w = 0; w < 16; w++) begin
            m[w] = '0;
            for (int b = 0; b < 8; b++) m[w] = {m[w][55:0], blk[8*w + b]};
        end
        for (int i = 0; i < 8; i++) begin
            v[i]     = TB_IV[i];
            v[i + 8] = TB_C[i];
        end
        v[12] = v[12] ^ 64'd640;
        v[13] = v[13] ^ 64'd640;
        for (int rd = 0; rd < 16; rd++) begin
            s = rd % 10;
            for (int i = 0; i < 8; i++) begin
                res = gmix(v[GA[i]], v[GB[i]], v[GC[i]], v[GD[i]],
                           m[SIG[s][2*i]] ^ TB_C[SIG[s][2*i+1]],
                           m[SIG[s][2*i+1]] ^ TB_C[SIG[s][2*i]]);
                {v[GA[i]], v[GB[i]], v[GC[i]], v[GD[i]]} = res;
            end
        end
        for (int j = 0; j < 8; j++) h[511 - 64*j -: 64] = TB_IV[j] ^ v[j] ^ v[j + 8];
        return h;
    endfunction

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [639:0] rand_msg();
        logic [639:0] x;
        for (int k = 0; k < 20; k++) x[k*32 +: 32] = $urandom();
        return x;
    endfunction

    // Present msg with ena for exactly one edge (E0)
    task automatic start_hash(input logic [639:0] msg);
        din = msg;
        ena = 1'b1;
        do_edge();
        ena = 1'b0;
        din = rand_msg();
    endtask

    // Wait for rdy after E0; check latency, digest, pulse width and idle dout
    task automatic wait_rdy(input string tag, input logic [639:0] msg);
        bit early_dout = 0;
        bit seen = 0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            do_edge();
            if (rdy) begin
                seen = 1;
                check({tag, "_lat"}, 512'(n), 512'd33);
                check({tag, "_dig"}, dout, ref_blake512(msg));
                check({tag, "_pre0"}, 512'(early_dout), 512'd0);
                do_edge();
                check({tag, "_rdy_off"}, 512'(rdy), 512'd0);
                check({tag, "_dout_off"}, dout, 512'd0);
            end else if (dout != '0) begin
                early_dout = 1;
            end
        end
        if (!seen) check({tag, "_timeout"}, 512'd0, 512'd1);
    endtask

    // Count rdy pulses over a window of edges
    task automatic count_rdy(input int cycles, output int cnt);
        cnt = 0;
        for (int n = 0; n < cycles; n++) begin
            do_edge();
            if (rdy) cnt++;
        end
    endtask

    initial begin
        logic [639:0] msg_a, msg_b;
        int           cnt;

        rstb = 1'b0;
        ena  = 1'b0;
        din  = '0;
        repeat (10) do_edge();
        check("reset_rdy", 512'(rdy), 512'd0);
        check("reset_dout", dout, 512'd0);
        rstb = 1'b1;
        repeat (19) do_edge();

        // All-zero message
        start_hash('0);
        wait_rdy("zero", '0);

        // Re-strobe at E5 and E33 is ignored
        msg_a = rand_msg();
        msg_b = rand_msg();
        start_hash(msg_a);
        for (int n = 1; n <= 33; n++) begin
            do_edge();
            ena = 1'b0;
            if (n == 33) begin
                check("busy_rdy", 512'(rdy), 512'd1);
                check("busy_dig", dout, ref_blake512(msg_a));
            end
            if (n == 4 || n == 32) begin
                din = msg_b;
                ena = 1'b1;
            end
        end
        count_rdy(40, cnt);
        check("busy_noqueue", 512'(cnt), 512'd0);

        // Back-to-back: second ena on E34
        msg_a = rand_msg();
        msg_b = rand_msg();
        start_hash(msg_a);
        repeat (32) do_edge();
        din = msg_b;
        ena = 1'b1;
        do_edge();
        check("b2b_first_rdy", 512'(rdy), 512'd1);
        check("b2b_first_dig", dout, ref_blake512(msg_a));
        do_edge();
        ena = 1'b0;
        check("b2b_e34_rdy", 512'(rdy), 512'd0);
        check("b2b_e34_dout", dout, 512'd0);
        wait_rdy("b2b_second", msg_b);

        // Reset at E16 aborts the hash
        msg_a = rand_msg();
        start_hash(msg_a);
        repeat (16) do_edge();
        rstb = 1'b0;
        #1;
        check("abort_rdy", 512'(rdy), 512'd0);
        check("abort_dout", dout, 512'd0);
        repeat (3) do_edge();
        rstb = 1'b1;
        count_rdy(40, cnt);
        check("abort_no_rdy", 512'(cnt), 512'd0);
        msg_b = rand_msg();
        start_hash(msg_b);
        wait_rdy("abort_fresh", msg_b);

        // Random messages
        for (int t = 0; t < 100; t++) begin
            msg_a = rand_msg();
            start_hash(msg_a);
            wait_rdy("rand", msg_a);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
